// File: rtl/ones_counter_ctrl_pkg.sv
// Shared definitions for the ones-counter controller: ALU op codes, RF addresses,
// state encoding and the control vector driven onto the datapath.
// Build option: ONES_CTRL_FUSE_EN merges the INC state into a combined SHIFT_INC state.
package ones_counter_ctrl_pkg;

  // ALU op codes
  localparam logic [3:0] AluPass = 4'h0;
  localparam logic [3:0] AluInc  = 4'h1;
  localparam logic [3:0] AluShr  = 4'h6;
  localparam logic [3:0] AluZero = 4'h7;

  // Default register-file addresses
  localparam logic [3:0] DefCntAddr  = 4'd0;
  localparam logic [3:0] DefDataAddr = 4'd1;

  localparam int unsigned IterW = 5;

  // 3-bit binary state encoding; code 4 is INC or SHIFT_INC depending on the build
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StClear    = 3'd1,
    StLoad     = 3'd2,
    StTest     = 3'd3,
`ifdef ONES_CTRL_FUSE_EN
    StShiftInc = 3'd4,
`else
    StInc      = 3'd4,
`endif
    StShift    = 3'd5,
    StOut      = 3'd6,
    StDone     = 3'd7
  } state_e;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ie;
    logic [3:0] waa;
    logic [3:0] raa;
    logic [3:0] wab;
    logic [3:0] rab;
    logic       wea;
    logic       web;
    logic       rea;
    logic       reb;
    logic       oe;
    logic [3:0] s_alu1;
    logic [3:0] s_alu2;
  } ctrl_t;

endpackage

// File: rtl/ones_ctrl_decode.sv
// Moore output decode: maps the controller state onto the datapath control vector.
// Build option: ONES_CTRL_FUSE_EN adds the SHIFT_INC decode in place of INC.
module ones_ctrl_decode
  import ones_counter_ctrl_pkg::*;
#(
  parameter logic [3:0] CntAddr  = DefCntAddr,
  parameter logic [3:0] DataAddr = DefDataAddr
) (
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // Start from the all-idle vector, then assert only what each state needs
  always_comb begin
    ctrl_o        = '0;
    ctrl_o.s_alu1 = AluPass;
    ctrl_o.s_alu2 = AluPass;
    ctrl_o.busy   = (state_i != StIdle);
    unique case (state_i)
      StIdle: ;
      StClear: begin
        ctrl_o.rea    = 1'b1;
        ctrl_o.raa    = CntAddr;
        ctrl_o.s_alu1 = AluZero;
        ctrl_o.wea    = 1'b1;
        ctrl_o.waa    = CntAddr;
      end
      StLoad: begin
        ctrl_o.ie  = 1'b1;
        ctrl_o.web = 1'b1;
        ctrl_o.wab = DataAddr;
      end
      StTest: begin
        ctrl_o.reb = 1'b1;
        ctrl_o.rab = DataAddr;
      end
`ifdef ONES_CTRL_FUSE_EN
      // Dual-write RF: count increments on port A while data shifts on port B
      StShiftInc: begin
        ctrl_o.rea    = 1'b1;
        ctrl_o.raa    = CntAddr;
        ctrl_o.s_alu1 = AluInc;
        ctrl_o.wea    = 1'b1;
        ctrl_o.waa    = CntAddr;
        ctrl_o.reb    = 1'b1;
        ctrl_o.rab    = DataAddr;
        ctrl_o.s_alu2 = AluShr;
        ctrl_o.web    = 1'b1;
        ctrl_o.wab    = DataAddr;
      end
`else
      StInc: begin
        ctrl_o.rea    = 1'b1;
        ctrl_o.raa    = CntAddr;
        ctrl_o.s_alu1 = AluInc;
        ctrl_o.wea    = 1'b1;
        ctrl_o.waa    = CntAddr;
      end
`endif
      StShift: begin
        ctrl_o.reb    = 1'b1;
        ctrl_o.rab    = DataAddr;
        ctrl_o.s_alu2 = AluShr;
        ctrl_o.web    = 1'b1;
        ctrl_o.wab    = DataAddr;
      end
      StOut: begin
        ctrl_o.rea = 1'b1;
        ctrl_o.raa = CntAddr;
        ctrl_o.oe  = 1'b1;
      end
      StDone: begin
        ctrl_o.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ones_counter_ctrl.sv
// Sequencer for the ones-counter datapath: loads DataIn, then shifts/tests/increments
// until the data register reads zero, and finally latches the count to the output register.
// Build option: ONES_CTRL_FUSE_EN fuses increment and shift into one cycle.
module ones_counter_ctrl
  import ones_counter_ctrl_pkg::*;
#(
  parameter logic [3:0]  CntAddr  = DefCntAddr,
  parameter logic [3:0]  DataAddr = DefDataAddr,
  parameter int unsigned MaxIter  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] datapath_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ie_o,
  output logic [3:0]  waa_o,
  output logic [3:0]  raa_o,
  output logic [3:0]  wab_o,
  output logic [3:0]  rab_o,
  output logic        wea_o,
  output logic        web_o,
  output logic        rea_o,
  output logic        reb_o,
  output logic        oe_o,
  output logic [3:0]  s_alu1_o,
  output logic [3:0]  s_alu2_o
);

  localparam logic [IterW-1:0] IterMax = IterW'(MaxIter);

  state_e           state_q, state_d;
  logic [IterW-1:0] iter_q, iter_d;
  ctrl_t            ctrl;

  // State and iteration registers; reset aborts any run in progress
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state and iteration-count logic
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StClear;
      StClear: begin
        iter_d  = '0;
        state_d = StLoad;
      end
      StLoad:  state_d = StTest;
      // iter bound guarantees termination even if the data never reads zero
      StTest: begin
        if (datapath_i == '0 || iter_q == IterMax) begin
          state_d = StOut;
        end else if (datapath_i[0]) begin
`ifdef ONES_CTRL_FUSE_EN
          state_d = StShiftInc;
`else
          state_d = StInc;
`endif
        end else begin
          state_d = StShift;
        end
      end
`ifdef ONES_CTRL_FUSE_EN
      StShift, StShiftInc: begin
`else
      StInc:   state_d = StShift;
      StShift: begin
`endif
        if (iter_q != IterMax) iter_d = iter_q + 1'b1;
        state_d = StTest;
      end
      StOut:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  ones_ctrl_decode #(
    .CntAddr  (CntAddr),
    .DataAddr (DataAddr)
  ) u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign busy_o   = ctrl.busy;
  assign done_o   = ctrl.done;
  assign ie_o     = ctrl.ie;
  assign waa_o    = ctrl.waa;
  assign raa_o    = ctrl.raa;
  assign wab_o    = ctrl.wab;
  assign rab_o    = ctrl.rab;
  assign wea_o    = ctrl.wea;
  assign web_o    = ctrl.web;
  assign rea_o    = ctrl.rea;
  assign reb_o    = ctrl.reb;
  assign oe_o     = ctrl.oe;
  assign s_alu1_o = ctrl.s_alu1;
  assign s_alu2_o = ctrl.s_alu2;

endmodule

// File: tb/tb_ones_counter_ctrl.sv
// Directed bench for ones_counter_ctrl with a behavioural ones-counter datapath
// (dual-port RF, ALU1/ALU2, input mux, output register). Honours ONES_CTRL_FUSE_EN.
module tb_ones_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] datapath;
  logic        busy, done, ie, wea, web, rea, reb, oe;
  logic [3:0]  waa, raa, wab, rab, s_alu1, s_alu2;

  int total = 0;
  int bad   = 0;

`ifdef ONES_CTRL_FUSE_EN
  localparam bit Fused = 1'b1;
`else
  localparam bit Fused = 1'b0;
`endif

  always #5 clk = ~clk;

  ones_counter_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .datapath_i (datapath),
    .busy_o     (busy),
    .done_o     (done),
    .ie_o       (ie),
    .waa_o      (waa),
    .raa_o      (raa),
    .wab_o      (wab),
    .rab_o      (rab),
    .wea_o      (wea),
    .web_o      (web),
    .rea_o      (rea),
    .reb_o      (reb),
    .oe_o       (oe),
    .s_alu1_o   (s_alu1),
    .s_alu2_o   (s_alu2)
  );

  // Datapath model
  logic [15:0] rf [16];
  logic [15:0] rda, rdb, alu1, alu2, dp_out;

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a);
    case (op)
      4'h0:    return a;
      4'h1:    return a + 16'd1;
      4'h6:    return {1'b0, a[15:1]};
      4'h7:    return 16'h0000;
      default: return a;
    endcase
  endfunction

  assign rda      = rea ? rf[raa] : 16'h0000;
  assign rdb      = reb ? rf[rab] : 16'h0000;
  assign alu1     = alu(s_alu1, rda);
  assign alu2     = alu(s_alu2, rdb);
  assign datapath = rdb;

  always @(posedge clk) begin
    if (wea) rf[waa] <= alu1;
    if (web) rf[wab] <= ie ? data_in : alu2;
    if (oe)  dp_out  <= alu1;
  end

  wire [29:0] ctl = {ie, waa, raa, wab, rab, wea, web, rea, reb, oe, s_alu1, s_alu2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One START pulse; optionally re-pulse START during the first SHIFT-coded cycle
  task automatic run(input string tag, input logic [15:0] d, input int lat,
                     input logic [15:0] exp, input bit repulse);
    int cyc;
    bit pulsed;
    pulsed  = 1'b0;
    data_in = d;
    start   = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    chk({tag, ":clear_ctl"}, {rea, raa, s_alu1, wea, waa}, {1'b1, 4'd0, 4'h7, 1'b1, 4'd0});
    while (!done && cyc < 200) begin
      chk({tag, ":busy"}, busy, 1'b1);
      if (cyc == 2) chk({tag, ":load_ctl"}, {ie, web, wab}, {1'b1, 1'b1, 4'd1});
      if (repulse && !pulsed && s_alu2 == 4'h6) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      step();
      start = 1'b0;
      cyc++;
    end
    chk({tag, ":done_seen"}, done, 1'b1);
    chk({tag, ":latency"}, cyc, lat);
    chk({tag, ":out"}, dp_out, exp);
    chk({tag, ":busy_at_done"}, busy, 1'b1);
    step();
    chk({tag, ":done_pulse"}, {done, busy}, 2'b00);
    if (repulse) begin
      chk({tag, ":repulse_hit"}, pulsed, 1'b1);
      step();
      chk({tag, ":not_queued"}, {done, busy}, 2'b00);
    end
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;

    // Reset state
    #1;
    chk("reset_ctl", ctl, 30'd0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    step();
    rst = 1'b0;
    step();
    chk("idle_ctl", ctl, 30'd0);

    // 1..4: directed runs
    run("zero", 16'h0000, 5, 16'd0, 1'b0);
    run("ffff", 16'hFFFF, Fused ? 37 : 53, 16'd16, 1'b0);
    run("8001", 16'h8001, Fused ? 37 : 39, 16'd2, 1'b0);
    run("00a5", 16'h00A5, Fused ? 21 : 25, 16'd4, 1'b1);

    // 5: reset mid-SHIFT
    data_in = 16'h0003;
    start   = 1'b1;
    step();
    start = 1'b0;
    cyc   = 0;
    while (s_alu2 != 4'h6 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("rst_shift_reached", s_alu2, 4'h6);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", ctl, 30'd0);
    chk("rst_async_busy", {busy, done}, 2'b00);
    step();
    rst = 1'b0;
    step();
    chk("rst_stays_idle", {busy, ctl}, 31'd0);
    run("after_rst", 16'h0003, Fused ? 9 : 11, 16'd2, 1'b0);

    // 6: START held across two runs
    data_in = 16'h0F00;
    start   = 1'b1;
    step();
    cyc = 1;
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
    chk("hold1_latency", cyc, Fused ? 29 : 33);
    chk("hold1_out", dp_out, 16'd4);
    data_in = 16'h0001;
    cyc     = 0;
    step();
    cyc++;
    chk("hold_idle_gap", busy, 1'b0);
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
    chk("hold2_gap", cyc, Fused ? 8 : 9);
    chk("hold2_out", dp_out, 16'd1);
    start = 1'b0;
    step();
    step();
    chk("hold_end_idle", {busy, done}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
